// File: rtl/matrix_pkg.sv
// Shared types and helpers for the sequential matrix add/subtract unit.
package matrix_pkg;

  localparam int unsigned DEF_EW    = 8;
  localparam int unsigned DEF_MAX_N = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed saturation limits for an ew-bit two's complement element
  function automatic int sat_max(input int unsigned ew);
    return int'((32'd1 << (ew - 32'd1)) - 32'd1);
  endfunction

  function automatic int sat_min(input int unsigned ew);
    return -int'(32'd1 << (ew - 32'd1));
  endfunction

  function automatic int unsigned elem_count(input int unsigned n);
    return n * n;
  endfunction

endpackage

// File: rtl/elem_addsub.sv
// One lane of signed add/subtract with overflow detection and optional clamping.
module elem_addsub
  import matrix_pkg::*;
#(
  parameter int unsigned EW = DEF_EW
) (
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  input  logic          sub,
  input  logic          sat,
  output logic [EW-1:0] r,
  output logic          ovf
);

  logic [EW:0] sum;

  // One extra bit holds the true sign; a mismatch with bit EW-1 means the EW-bit result overflowed
  always_comb begin
    sum = sub ? ({a[EW-1], a} - {b[EW-1], b}) : ({a[EW-1], a} + {b[EW-1], b});
    ovf = sum[EW] ^ sum[EW-1];
    r   = sum[EW-1:0];
    if (ovf && sat) begin
      r = sum[EW] ? EW'(sat_min(EW)) : EW'(sat_max(EW));
    end
  end

endmodule

// File: rtl/matrix_addsub_seq.sv
// Sequential N x N matrix add/subtract, LANES elements per cycle, start/done handshake.
module matrix_addsub_seq
  import matrix_pkg::*;
#(
  parameter  int unsigned EW    = DEF_EW,
  parameter  int unsigned MAX_N = DEF_MAX_N,
  parameter  int unsigned LANES = 1,
  localparam int unsigned DW    = $clog2(MAX_N + 1),
  localparam int unsigned FLAT  = MAX_N * MAX_N * EW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op_sub,
  input  logic            op_sat,
  input  logic [DW-1:0]   dim,
  input  logic [FLAT-1:0] matrix_a,
  input  logic [FLAT-1:0] matrix_b,
  output logic            busy,
  output logic            done,
  output logic [FLAT-1:0] result_out,
  output logic            overflow,
  output logic            err
);

  localparam int unsigned TOTAL = MAX_N * MAX_N;
  localparam int unsigned KW    = $clog2(TOTAL + LANES + 1);
  localparam int unsigned IW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  state_e          state;
  state_e          next_state;
  logic [FLAT-1:0] a_q;
  logic [FLAT-1:0] b_q;
  logic            sub_q;
  logic            sat_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   cnt_q;
  logic            dim_ok_c;
  logic            last_c;

  logic [LANES-1:0] lane_act;
  logic [LANES-1:0] lane_ovf;
  logic [IW-1:0]    lane_sel [LANES];
  logic [EW-1:0]    lane_r   [LANES];

  assign dim_ok_c = (dim != '0) && (dim <= DW'(MAX_N));
  assign last_c   = (k_q + KW'(LANES)) >= cnt_q;

  // Lanes past the last active element are parked on index 0 and never written back
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [KW-1:0] idx;
    assign idx         = k_q + KW'(l);
    assign lane_act[l] = idx < cnt_q;
    assign lane_sel[l] = lane_act[l] ? IW'(idx) : '0;

    elem_addsub #(.EW(EW)) u_elem (
      .a   (a_q[int'(lane_sel[l]) * int'(EW) +: EW]),
      .b   (b_q[int'(lane_sel[l]) * int'(EW) +: EW]),
      .sub (sub_q),
      .sat (sat_q),
      .r   (lane_r[l]),
      .ovf (lane_ovf[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = dim_ok_c ? RUN : DONE;
      RUN:     if (last_c) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latches, index counter, result register and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      result_out <= '0;
      overflow   <= 1'b0;
      err        <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      sub_q      <= 1'b0;
      sat_q      <= 1'b0;
      k_q        <= '0;
      cnt_q      <= '0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q        <= matrix_a;
            b_q        <= matrix_b;
            sub_q      <= op_sub;
            sat_q      <= op_sat;
            k_q        <= '0;
            cnt_q      <= dim_ok_c ? KW'(elem_count(32'(dim))) : '0;
            result_out <= '0;
            overflow   <= 1'b0;
            err        <= ~dim_ok_c;
          end
        end
        RUN: begin
          for (int i = 0; i < int'(TOTAL); i++) begin
            for (int l = 0; l < int'(LANES); l++) begin
              if (lane_act[l] && (lane_sel[l] == IW'(i))) begin
                result_out[i * int'(EW) +: EW] <= lane_r[l];
              end
            end
          end
          overflow <= overflow | (|(lane_ovf & lane_act));
          k_q      <= k_q + KW'(LANES);
        end
        default: ;
      endcase
    end
  end

endmodule
